// File: rtl/camera_pattern_source_pkg.sv
// Shared types and constants for the camera test-pattern source: state
// encoding, pattern codes and pixel width.
package camera_pattern_source_pkg;

  localparam int PIXEL_WIDTH = 12;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LINE   = 2'b01,
    HBLANK = 2'b10,
    VBLANK = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    PAT_RAMP    = 2'b00,
    PAT_CHECKER = 2'b01,
    PAT_SOLID   = 2'b10,
    PAT_TAG     = 2'b11
  } pattern_t;

  localparam pixel_t PIXEL_FULL = 12'hFFF;
  localparam pixel_t PIXEL_MID  = 12'h800;

endpackage

// File: rtl/camera_pattern_source_if.sv
// Pixel request bus between the timing generator and the pixel-value
// generator: coordinates and pattern in, pixel value out.
interface camera_pattern_source_if;
  import camera_pattern_source_pkg::*;

  pattern_t    pattern;
  logic [15:0] x;
  logic [15:0] y;
  logic [3:0]  frame_tag;
  pixel_t      data;

  modport master (output pattern, x, y, frame_tag, input data);
  modport slave  (input pattern, x, y, frame_tag, output data);

endinterface

// File: rtl/camera_pattern_pixel.sv
// Combinational pixel value for a given pattern, coordinate and frame tag;
// the parent registers the result.
module camera_pattern_pixel
  import camera_pattern_source_pkg::*;
(
  camera_pattern_source_if.slave px
);

  always_comb begin
    px.data = '0;
    unique case (px.pattern)
      PAT_RAMP:    px.data = pixel_t'(px.x + px.y);
      PAT_CHECKER: px.data = (px.x[4] ^ px.y[4]) ? PIXEL_FULL : '0;
      PAT_SOLID:   px.data = PIXEL_MID;
      PAT_TAG:     px.data = {px.frame_tag, px.x[7:0]};
      default:     px.data = '0;
    endcase
  end

endmodule

// File: rtl/camera_pattern_source.sv
// Camera-style frame generator: FVal/LVal timing with horizontal and vertical
// blanking, selectable test patterns and a completed-frame counter.
module camera_pattern_source
  import camera_pattern_source_pkg::*;
#(
  parameter int COLUMN_WIDTH = 1280,
  parameter int ROW_COUNT    = 960,
  parameter int H_BLANK      = 16,
  parameter int V_BLANK      = 64
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iEnable,
  input  logic [1:0] iPattern,
  output pixel_t     oData,
  output logic       oFVal,
  output logic       oLVal,
  output logic       oFrameDone,
  output logic [7:0] oFrameCount
);

  localparam logic [15:0] X_LAST = 16'(COLUMN_WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(ROW_COUNT - 1);
  localparam logic [15:0] H_LAST = 16'(H_BLANK - 1);
  localparam logic [15:0] V_LAST = 16'(V_BLANK - 1);

  state_t      state, state_n;
  logic [15:0] x, x_n;
  logic [15:0] y, y_n;
  logic [15:0] blank_cnt, blank_n;
  pattern_t    pattern, pattern_n;
  logic        fval_n, lval_n, done_n;
  logic [7:0]  count_n;

  camera_pattern_source_if px ();

  // The pixel generator sees next-cycle coordinates so the registered data
  // lines up with the registered FVal/LVal of the same pixel.
  assign px.pattern   = pattern_n;
  assign px.x         = x_n;
  assign px.y         = y_n;
  assign px.frame_tag = count_n[3:0];

  camera_pattern_pixel u_pixel (.px(px));

  // NOTE: every variable is given a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    x_n       = x;
    y_n       = y;
    blank_n   = blank_cnt;
    pattern_n = pattern;
    done_n    = 1'b0;
    count_n   = oFrameCount;

    unique case (state)
      IDLE: begin
        if (iEnable) begin
          state_n   = LINE;
          x_n       = '0;
          y_n       = '0;
          pattern_n = pattern_t'(iPattern);
        end
      end
      LINE: begin
        if (x == X_LAST) begin
          blank_n = '0;
          if (y < Y_LAST) begin
            state_n = HBLANK;
          end else begin
            state_n = VBLANK;
            done_n  = 1'b1;
            count_n = oFrameCount + 8'd1;
          end
        end else begin
          x_n = x + 16'd1;
        end
      end
      HBLANK: begin
        if (blank_cnt == H_LAST) begin
          state_n = LINE;
          x_n     = '0;
          y_n     = y + 16'd1;
        end else begin
          blank_n = blank_cnt + 16'd1;
        end
      end
      VBLANK: begin
        if (blank_cnt == V_LAST) begin
          if (iEnable) begin
            state_n   = LINE;
            x_n       = '0;
            y_n       = '0;
            pattern_n = pattern_t'(iPattern);
          end else begin
            state_n = IDLE;
          end
        end else begin
          blank_n = blank_cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    // FVal and LVal both derive from the next state, so entering VBLANK
    // drops them together.
    fval_n = (state_n == LINE) || (state_n == HBLANK);
    lval_n = (state_n == LINE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      blank_cnt   <= '0;
      pattern     <= PAT_RAMP;
      oData       <= '0;
      oFVal       <= 1'b0;
      oLVal       <= 1'b0;
      oFrameDone  <= 1'b0;
      oFrameCount <= '0;
    end else begin
      state       <= state_n;
      x           <= x_n;
      y           <= y_n;
      blank_cnt   <= blank_n;
      pattern     <= pattern_n;
      oData       <= lval_n ? px.data : '0;
      oFVal       <= fval_n;
      oLVal       <= lval_n;
      oFrameDone  <= done_n;
      oFrameCount <= count_n;
    end
  end

endmodule

// File: doc/camera_pattern_source.md
CAMERA_PATTERN_SOURCE -- requirements
Module: camera_pattern_source

Interface
REQ-001 SHALL have parameter COLUMN_WIDTH, default 1280, giving active pixels per line.
REQ-002 SHALL have parameter ROW_COUNT, default 960, giving active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 16, giving cycles with LVal low between lines, minimum 1.
REQ-004 SHALL have parameter V_BLANK, default 64, giving cycles with FVal and LVal low between frames, minimum 1.
REQ-005 SHALL have port iClock, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-006 SHALL have port iReset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port iEnable, input, 1 bit: when high, frames are generated continuously.
REQ-008 SHALL have port iPattern, input, 2 bits: pattern select, latched at frame start.
REQ-009 SHALL have port oData, output, 12 bits: pixel data.
REQ-010 SHALL have port oFVal, output, 1 bit: frame valid.
REQ-011 SHALL have port oLVal, output, 1 bit: line valid.
REQ-012 SHALL have port oFrameDone, output, 1 bit: one-cycle pulse at frame end.
REQ-013 SHALL have port oFrameCount, output, 8 bits: number of completed frames, wrapping modulo 256.

Function
REQ-014 SHALL drive every output from a register, with no combinational path from any input to any output.
REQ-015 SHALL implement states IDLE, LINE, HBLANK and VBLANK.
REQ-016 In IDLE with iEnable=1 sampled, the block SHALL enter LINE, set X=0 and Y=0, latch iPattern, and present first pixel with oFVal=oLVal=1 after that same edge.
REQ-017 In LINE, the block SHALL increment X each cycle; after pixel X=COLUMN_WIDTH-1 it SHALL go to HBLANK if Y<ROW_COUNT-1, else to VBLANK.
REQ-018 In HBLANK, the block SHALL hold oFVal=1 and oLVal=0 for exactly H_BLANK cycles, then return to LINE with X=0 and Y incremented.
REQ-019 On entry to VBLANK, oFVal and oLVal SHALL fall on the same edge, so no cycle has FVal=1 with LVal=0 after the last line.
REQ-020 VBLANK SHALL last exactly V_BLANK cycles with oFVal=oLVal=0; it SHALL then go to LINE (new frame) if iEnable=1, else to IDLE.
REQ-021 oFrameDone SHALL pulse for one cycle on the VBLANK entry edge, and oFrameCount SHALL increment on the same edge.
REQ-022 Deasserting iEnable mid-frame SHALL NOT truncate the frame: the current frame completes, including VBLANK, before IDLE.
REQ-023 oData SHALL be 0 whenever oLVal=0.
REQ-024 Pattern 00 (ramp) SHALL output oData = (X+Y) mod 4096.
REQ-025 Pattern 01 (checker) SHALL output oData = 12'hFFF when X[4] XOR Y[4] is 1, else 0.
REQ-026 Pattern 10 (solid) SHALL output oData = 12'h800.
REQ-027 Pattern 11 (frame tag) SHALL output oData = {oFrameCount[3:0], X[7:0]}.
REQ-028 Changing iPattern mid-frame SHALL have no effect until the next frame start.
REQ-029 X and Y counters SHALL be 16 bits each; parameters above 65535 are unsupported.

Reset
REQ-030 While iReset=0, the block SHALL be in IDLE with X=0, Y=0, latched pattern=00, and blank counter=0.
REQ-031 While iReset=0, outputs SHALL be oData=0, oFVal=0, oLVal=0, oFrameDone=0 and oFrameCount=0.
REQ-032 Reset asserted mid-frame SHALL drop oFVal and oLVal immediately (asynchronously), with no frame-done pulse.
REQ-033 After reset release, the first frame SHALL start only on a sampled iEnable=1.

Structure
REQ-034 A shared package SHALL hold the state encoding (IDLE=2'b00, LINE=2'b01, HBLANK=2'b10, VBLANK=2'b11), the pattern codes, and the 12-bit pixel width constant.
REQ-035 Pixel value generation SHALL live in one sub-module, camera_pattern_pixel, combinational from (pattern, X, Y, frame count), registered by the parent.

Verification (COLUMN_WIDTH=4, ROW_COUNT=3, H_BLANK=2, V_BLANK=3 unless stated)
REQ-036 Bench SHALL cover: reset, then iEnable=1, pattern 00 -> oFVal high for 16 cycles; oLVal pattern 4 high/2 low/4 high/2 low/4 high; oData 0,1,2,3 / 1,2,3,4 / 2,3,4,5.
REQ-037 Bench SHALL cover: last pixel of line 2 -> next edge has oFVal=oLVal=0 together, oFrameDone=1 for one cycle, oFrameCount 0->1, then 3 blank cycles before the next frame's first pixel.
REQ-038 Bench SHALL cover: iEnable dropped during line 1 -> frame completes all 12 pixels plus VBLANK, then IDLE with outputs low indefinitely.
REQ-039 Bench SHALL cover: iPattern switched 00->10 mid-frame -> current frame keeps ramp data, next frame is all 12'h800.
REQ-040 Bench SHALL cover: iReset pulsed low during line 1 -> oFVal, oLVal and oData go to 0 asynchronously, oFrameCount=0, and the restart begins with X=0, Y=0.
REQ-041 Bench SHALL cover: COLUMN_WIDTH=32, pattern 01 -> line 0 data is 0 for X=0..15 and 12'hFFF for X=16..31; pattern 11 on frame 1 gives oData 12'h100,12'h101,...
